bcd_digit_counter: RTL
======================

BCD_DIGIT_COUNTER -- requirements
Module: bcd_digit_counter

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of BCD digits, legal range 1..8.
REQ-002 Parameter BUZZ_CYCLES, default 1: buzzer-high duration in clocks after a wrap, legal range 1..255.
REQ-003 Clock is clk_1Hz; reset is result_reset, synchronous and active-high.
REQ-004 clk_1Hz  input  1  counting clock; all state updates on its rising edge.
REQ-005 result_reset  input  1  synchronous active-high reset.
REQ-006 updown  input  1  1 = count up, 0 = count down.
REQ-007 result_load  input  1  load load_value into count.
REQ-008 load_value  input  4*NUM_DIGITS  packed BCD preset; digit 0 is in bits [3:0].
REQ-009 state  input  1  1 = hold (stop), 0 = run.
REQ-010 count  output  4*NUM_DIGITS  packed BCD count, registered.
REQ-011 tc  output  1  one-clock pulse on any wrap-around.
REQ-012 buzzer  output  1  high for BUZZ_CYCLES clocks after a wrap.
REQ-013 busy_run  output  1  1 while the FSM is in RUN.

Function
REQ-014 The FSM SHALL have two states, STOP and RUN: STOP->RUN when state=0; RUN->STOP when state=1; the transition takes effect on the same edge.
REQ-015 Priority each edge: result_reset > result_load > STOP hold > count step.
REQ-016 Load SHALL write load_value in one clock regardless of FSM state; any digit >9 is clamped to 9; tc is not asserted on a load.
REQ-017 In RUN with updown=1, digit 0 SHALL increment; a digit at 9 becomes 0 and carries into the next digit in the same clock.
REQ-018 In RUN with updown=0, digit 0 SHALL decrement; a digit at 0 becomes 9 and borrows from the next digit in the same clock.
REQ-019 Up-wrap from all 9s to all 0s, and down-wrap from all 0s to all 9s, SHALL each assert tc for exactly one clock, concurrent with the wrapped count.
REQ-020 Counting SHALL continue during buzzer activity; the buzzer never stalls the counter.
REQ-021 On tc, buzzer SHALL go high on the next edge and stay high for BUZZ_CYCLES clocks; a tc during an active buzz reloads the timer to BUZZ_CYCLES.
REQ-022 A change of updown SHALL take effect on the next step, with no extra latency and no spurious tc.
REQ-023 In STOP, count SHALL hold; buzzer timing SHALL still run down.

Reset
REQ-024 result_reset SHALL set count to all 9s if updown=0, otherwise to 0.
REQ-025 result_reset SHALL set tc=0, buzzer=0, the buzzer timer to 0, and the FSM to STOP (busy_run=0).
REQ-026 Reset asserted mid-buzz SHALL drop buzzer on that edge.

Configuration
REQ-027 Macro BCD_ALARM_EN: when defined, adds input alarm_value (4*NUM_DIGITS) and output alarm; alarm is registered and goes high the clock after count equals alarm_value; alarm resets to 0.
REQ-028 Without BCD_ALARM_EN, neither port exists and no compare logic is built.

Structure
REQ-029 Package bcd_counter_pkg SHALL hold the constant BCD_W=4, the constant BCD_MAX=4'd9, and the FSM state enum (STOP, RUN).
REQ-030 Sub-module bcd_digit SHALL implement a one-digit counter with en, up, load, carry/borrow in, and carry/borrow out; it is instantiated NUM_DIGITS times in a generate loop.

Verification (NUM_DIGITS=4, BUZZ_CYCLES=2)
REQ-031 result_reset with updown=0 -> count=16'h9999, buzzer=0, busy_run=0; result_reset with updown=1 -> count=16'h0000.
REQ-032 Up from 16'h0099, state=0 -> next count 16'h0100, no tc.
REQ-033 Load 16'h9998, updown=1, run 2 clocks -> 9999, then 0000 with tc=1 for 1 clock; buzzer high for exactly 2 clocks after that.
REQ-034 Load 16'h0000, updown=0 -> next 16'h9999 with tc=1; load 16'hA3F1 -> count 16'h9391.
REQ-035 In RUN at 16'h0042, set state=1 for 5 clocks -> count stays 16'h0042; result_load together with state=1 -> load still applied.
REQ-036 With BCD_ALARM_EN, alarm_value=16'h0010 while counting up from 0008 -> alarm high starting the clock after count=0010, for 1 clock.

Source files
------------

// File: rtl/bcd_counter_pkg.sv
// Shared constants and FSM state type for the BCD digit counter.
// Optional alarm compare is enabled with `define BCD_ALARM_EN.
package bcd_counter_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam int unsigned BUZZ_W = 8;

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } fsm_e;

endpackage

// File: rtl/bcd_digit_counter_if.sv
// Control/status bundle of the BCD digit counter.
// Alarm signals exist only with `define BCD_ALARM_EN.
interface bcd_digit_counter_if
  import bcd_counter_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);
  logic                        updown;
  logic                        result_load;
  logic [BCD_W*NUM_DIGITS-1:0] load_value;
  logic                        state;
  logic [BCD_W*NUM_DIGITS-1:0] count;
  logic                        tc;
  logic                        buzzer;
  logic                        busy_run;
`ifdef BCD_ALARM_EN
  logic [BCD_W*NUM_DIGITS-1:0] alarm_value;
  logic                        alarm;
`endif

  modport master (
    output updown, result_load, load_value, state,
`ifdef BCD_ALARM_EN
    output alarm_value,
    input  alarm,
`endif
    input  count, tc, buzzer, busy_run
  );

  modport slave (
    input  updown, result_load, load_value, state,
`ifdef BCD_ALARM_EN
    input  alarm_value,
    output alarm,
`endif
    output count, tc, buzzer, busy_run
  );

endinterface

// File: rtl/bcd_digit.sv
// One BCD digit: load with clamp, up/down step gated by carry/borrow in.
// Carry/borrow out is combinational so a whole chain ripples in one clock.
module bcd_digit
  import bcd_counter_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rst_up_i,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             load_i,
  input  logic [BCD_W-1:0] load_val_i,
  input  logic             ci_i,
  output logic [BCD_W-1:0] q_o,
  output logic             co_o
);

  logic [BCD_W-1:0] q_q, q_d, ld_val;
  logic             at_edge;

  assign ld_val  = (load_val_i > BCD_MAX) ? BCD_MAX : load_val_i;
  assign at_edge = up_i ? (q_q == BCD_MAX) : (q_q == '0);
  assign co_o    = ci_i & at_edge;
  assign q_o     = q_q;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = ld_val;
    end else if (en_i && ci_i) begin
      if (up_i) q_d = at_edge ? '0 : q_q + 1'b1;
      else      q_d = at_edge ? BCD_MAX : q_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) q_q <= rst_up_i ? '0 : BCD_MAX;
    else       q_q <= q_d;
  end

endmodule

// File: rtl/bcd_digit_counter.sv
// Multi-digit BCD up/down counter with STOP/RUN FSM, wrap pulse and buzzer.
// `define BCD_ALARM_EN adds alarm_value input and registered alarm output.
module bcd_digit_counter
  import bcd_counter_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int BUZZ_CYCLES = 1
) (
  input  logic                        clk_1Hz,
  input  logic                        result_reset,
  input  logic                        updown,
  input  logic                        result_load,
  input  logic [BCD_W*NUM_DIGITS-1:0] load_value,
  input  logic                        state,
`ifdef BCD_ALARM_EN
  input  logic [BCD_W*NUM_DIGITS-1:0] alarm_value,
  output logic                        alarm,
`endif
  output logic [BCD_W*NUM_DIGITS-1:0] count,
  output logic                        tc,
  output logic                        buzzer,
  output logic                        busy_run
);

  localparam logic [BUZZ_W-1:0] BUZZ_LD = BUZZ_W'(BUZZ_CYCLES);

  fsm_e              fsm_q, fsm_d;
  logic              tc_q, tc_d;
  logic [BUZZ_W-1:0] tmr_q, tmr_d;
  logic              step;
  logic [NUM_DIGITS:0] chain;

  // FSM follows state on the same edge, so a run edge also steps
  assign fsm_d    = state ? STOP : RUN;
  assign step     = !result_load && (fsm_d == RUN);
  assign chain[0] = 1'b1;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    bcd_digit u_dig (
      .clk_i      (clk_1Hz),
      .rst_i      (result_reset),
      .rst_up_i   (updown),
      .en_i       (step),
      .up_i       (updown),
      .load_i     (result_load),
      .load_val_i (load_value[g*BCD_W +: BCD_W]),
      .ci_i       (chain[g]),
      .q_o        (count[g*BCD_W +: BCD_W]),
      .co_o       (chain[g+1])
    );
  end

  assign tc_d = step && chain[NUM_DIGITS];

  always_comb begin
    tmr_d = tmr_q;
    if (tc_q)              tmr_d = BUZZ_LD;
    else if (tmr_q != '0)  tmr_d = tmr_q - 1'b1;
  end

  always_ff @(posedge clk_1Hz) begin
    if (result_reset) begin
      fsm_q <= STOP;
      tc_q  <= 1'b0;
      tmr_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      tc_q  <= tc_d;
      tmr_q <= tmr_d;
    end
  end

  assign tc       = tc_q;
  assign buzzer   = (tmr_q != '0);
  assign busy_run = (fsm_q == RUN);

`ifdef BCD_ALARM_EN
  logic alarm_q;

  always_ff @(posedge clk_1Hz) begin
    if (result_reset) alarm_q <= 1'b0;
    else              alarm_q <= (count == alarm_value);
  end

  assign alarm = alarm_q;
`endif

endmodule
